// File: rtl/z_tile_scheduler_if.sv
// z_tile_scheduler_if
//   Bundles every non-clock signal of the z tile scheduler.
//   slave  : the scheduler side. It takes setup records, drives the z_interpolation datapath,
//            receives its result, and produces the ready/valid result stream.
//   master : the environment side. It supplies records, models the datapath and consumes results.
//   Signal groups:
//     tri_* : setup record handshake, carrying GPUF coefficients and an inclusive bounding box.
//     zi_*  : pixel coordinates and held coefficients sent to the datapath, plus its z result.
//     out_* : interpolated z with its coordinates and end-of-triangle flag (ready/valid).
//     busy  : the scheduler is working or still holds results.
interface z_tile_scheduler_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [26:0] tri_dzdx;
    logic [26:0] tri_dzdy;
    logic [26:0] tri_c;
    logic [4:0]  tri_x_min;
    logic [4:0]  tri_x_max;
    logic [4:0]  tri_y_min;
    logic [4:0]  tri_y_max;

    logic [4:0]  zi_x;
    logic [4:0]  zi_y;
    logic [26:0] zi_dzdx;
    logic [26:0] zi_dzdy;
    logic [26:0] zi_c;
    logic [26:0] zi_z;

    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_z;
    logic [4:0]  out_x;
    logic [4:0]  out_y;
    logic        out_last;
    logic        busy;

    modport slave (
        input  tri_valid, tri_dzdx, tri_dzdy, tri_c,
               tri_x_min, tri_x_max, tri_y_min, tri_y_max,
               zi_z, out_ready,
        output tri_ready, zi_x, zi_y, zi_dzdx, zi_dzdy, zi_c,
               out_valid, out_z, out_x, out_y, out_last, busy
    );

    modport master (
        output tri_valid, tri_dzdx, tri_dzdy, tri_c,
               tri_x_min, tri_x_max, tri_y_min, tri_y_max,
               zi_z, out_ready,
        input  tri_ready, zi_x, zi_y, zi_dzdx, zi_dzdy, zi_c,
               out_valid, out_z, out_x, out_y, out_last, busy
    );
endinterface

// File: rtl/z_tile_scheduler.sv
// z_tile_scheduler
//   Scans one triangle's bounding box inside a 32x32 tile in row-major order. It issues at
//   most one pixel per cycle to the non-stallable z_interpolation datapath. Each datapath
//   result is paired with its coordinates and queued for a ready/valid consumer. A credit
//   check on the issue path keeps the output FIFO from ever overflowing.
//   Ports:
//     clk : clock, all logic on the rising edge
//     rst : asynchronous active-low reset
//     bus : z_tile_scheduler_if.slave (setup record, datapath link, result stream, busy)
//   Parameters:
//     PIPE_LAT   : number of cycles from the issue decision to the matching zi_z being valid.
//                  The datapath result is therefore captured PIPE_LAT cycles after issue.
//     FIFO_DEPTH : number of output FIFO entries; must be a power of 2 and at least 2.
//                  Full throughput needs FIFO_DEPTH >= PIPE_LAT+1.
module z_tile_scheduler #(
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    z_tile_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PIPE_LAT + FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] x;
        logic [4:0] y;
        logic       last;
    } token_t;

    typedef struct packed {
        logic [26:0] z;
        logic [4:0]  x;
        logic [4:0]  y;
        logic        last;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    x_min_q;
    logic [4:0]    x_max_q;
    logic [4:0]    y_max_q;
    logic [4:0]    scan_x;       // next pixel to issue
    logic [4:0]    scan_y;
    logic [CW-1:0] in_flight;
    token_t        line [PIPE_LAT];
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;

    logic          accept;
    logic          bbox_empty;
    logic          scan_last;
    logic          issue;
    logic          capture;
    logic          pop;
    logic          fifo_nonempty;
    logic [CW-1:0] credit_used;
    entry_t        head;

    assign bbox_empty    = (bus.tri_x_min > bus.tri_x_max) || (bus.tri_y_min > bus.tri_y_max);
    assign accept        = bus.tri_valid && (state == IDLE);
    assign scan_last     = (scan_x == x_max_q) && (scan_y == y_max_q);
    assign capture       = line[PIPE_LAT-1].valid;
    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty && bus.out_ready;

    // Every issued token will land in the FIFO eventually. Therefore in_flight + fifo_count
    // bounds future occupancy. The head leaving this cycle frees its slot in time for the
    // new token, and that freed slot is what allows one issue per cycle in steady state.
    assign credit_used = in_flight + CW'(fifo_count) - CW'(pop);
    assign issue       = (state == SCAN) && (credit_used < CW'(FIFO_DEPTH));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so that every flop samples
        // pre-edge values; a blocking assignment here would create order-dependent races.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block receives a default first. Without that, any path
        // that does not assign a signal would infer a latch.
        state_nxt     = state;
        bus.tri_ready = 1'b0;
        unique case (state)
            IDLE: begin
                bus.tri_ready = 1'b1;
                // An empty box consumes the record and stays here.
                if (bus.tri_valid && !bbox_empty) state_nxt = SCAN;
            end
            SCAN: begin
                if (issue && scan_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (in_flight == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------- setup record and scan
    // The coefficients change only on a new record. A record is accepted only in IDLE, after
    // the previous triangle's last token has been captured. The datapath can therefore
    // sample zi_c as late as it likes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_max_q     <= '0;
            scan_x      <= '0;
            scan_y      <= '0;
            bus.zi_x    <= '0;
            bus.zi_y    <= '0;
            bus.zi_dzdx <= '0;
            bus.zi_dzdy <= '0;
            bus.zi_c    <= '0;
        end else if (accept) begin
            x_min_q     <= bus.tri_x_min;
            x_max_q     <= bus.tri_x_max;
            y_max_q     <= bus.tri_y_max;
            scan_x      <= bus.tri_x_min;
            scan_y      <= bus.tri_y_min;
            bus.zi_dzdx <= bus.tri_dzdx;
            bus.zi_dzdy <= bus.tri_dzdy;
            bus.zi_c    <= bus.tri_c;
        end else if (issue) begin
            bus.zi_x <= scan_x;
            bus.zi_y <= scan_y;
            if (scan_x == x_max_q) begin
                scan_x <= x_min_q;
                scan_y <= scan_y + 5'd1;   // wraps harmlessly after the final row
            end else begin
                scan_x <= scan_x + 5'd1;
            end
        end
    end

    // ------------------------------------ token shift line and in_flight
    // This line runs in lock-step with the datapath. A token reaches the last stage in
    // exactly the cycle in which its zi_z is valid. Clearing the line on reset means stale
    // datapath results are never captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) line[i] <= '0;
            in_flight <= '0;
        end else begin
            line[0] <= token_t'{valid: issue, x: scan_x, y: scan_y, last: scan_last};
            for (int i = 1; i < PIPE_LAT; i++) line[i] <= line[i-1];
            in_flight <= in_flight + CW'(issue) - CW'(capture);
        end
    end

    // ----------------------------------------------------- output FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(capture) - (AW+1)'(pop);
        end
    end

    // NOTE: the storage array has no reset. Validity is tracked entirely by the pointers
    // and the count, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= entry_t'{z: bus.zi_z, x: line[PIPE_LAT-1].x,
                                         y: line[PIPE_LAT-1].y, last: line[PIPE_LAT-1].last};
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign bus.out_valid = fifo_nonempty;
    assign bus.out_z     = head.z;
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.out_last  = head.last;
    assign bus.busy      = (state != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_z_tile_scheduler.sv
// tb_z_tile_scheduler
//   Scoreboard bench for z_tile_scheduler. Each record pushes its expected results, in
//   row-major order, as z = c ^ {y,x}. A datapath stub produces zi_z. It carries the
//   coordinates through the pipeline but reads zi_c only at its output, so coefficients that
//   change too early corrupt z. All sampling and driving happen on the falling clock edge.
module tb_z_tile_scheduler;
    localparam int PIPE_LAT   = 7;
    localparam int FIFO_DEPTH = 8;   // PIPE_LAT + 1

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    z_tile_scheduler_if bus ();

    z_tile_scheduler #(
        .PIPE_LAT  (PIPE_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Datapath stub: zi_z is valid PIPE_LAT cycles after the issue decision, i.e.
    // PIPE_LAT-1 register stages after the coordinates appear on zi_x/zi_y.
    logic [9:0] dp_pipe [PIPE_LAT-1];
    always @(posedge clk) begin
        dp_pipe[0] <= {bus.zi_y, bus.zi_x};
        for (int i = 1; i < PIPE_LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign bus.zi_z = bus.zi_c ^ {17'd0, dp_pipe[PIPE_LAT-2]};

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         n_out    = 0;
    int         cyc_log [int];
    logic [37:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Compare any result transferred at the coming edge, then advance to the next falling edge.
    task automatic tick();
        if (rst && bus.out_valid && bus.out_ready) begin
            cyc_log[n_out] = cyc;
            n_out++;
            if (sb.size() == 0) check("unexpected_out", 1, 0);
            else check("out_entry", {bus.out_z, bus.out_x, bus.out_y, bus.out_last}, sb.pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [26:0] c, input logic [4:0] x0, input logic [4:0] x1,
                        input logic [4:0] y0, input logic [4:0] y1);
        bit accepted = 0;
        bit got_rdy;
        if (x0 <= x1 && y0 <= y1) begin
            for (int y = int'(y0); y <= int'(y1); y++) begin
                for (int x = int'(x0); x <= int'(x1); x++) begin
                    logic [4:0] xs = 5'(x);
                    logic [4:0] ys = 5'(y);
                    sb.push_back({c ^ {17'd0, ys, xs}, xs, ys, (x == int'(x1) && y == int'(y1))});
                end
            end
        end
        bus.tri_valid = 1'b1;
        bus.tri_c     = c;
        bus.tri_dzdx  = 27'($urandom);
        bus.tri_dzdy  = 27'($urandom);
        bus.tri_x_min = x0;
        bus.tri_x_max = x1;
        bus.tri_y_min = y0;
        bus.tri_y_max = y1;
        for (int i = 0; i < 4000; i++) begin
            got_rdy = bus.tri_ready;
            tick();
            if (got_rdy) begin
                accepted = 1;
                break;
            end
        end
        bus.tri_valid = 1'b0;
        if (!accepted) check("tri_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.busy && sb.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        check(tag, done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        logic [9:0] prev;
        logic [9:0] cur;

        bus.tri_valid = 1'b0;
        bus.tri_c     = '0;
        bus.tri_dzdx  = '0;
        bus.tri_dzdy  = '0;
        bus.tri_x_min = '0;
        bus.tri_x_max = '0;
        bus.tri_y_min = '0;
        bus.tri_y_max = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        check("rst_tri_ready", bus.tri_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_zi_xy", {bus.zi_y, bus.zi_x}, 0);
        check("rst_zi_c", bus.zi_c, 0);

        // 1: 2x2 box, free-running consumer
        bus.out_ready = 1'b1;
        send(27'h100, 5'd0, 5'd1, 5'd0, 5'd1);
        check("t1_zi_c_latched", bus.zi_c, 27'h100);
        check("t1_zi_dzdx_latched", bus.zi_dzdx, bus.tri_dzdx);
        wait_idle("t1_idle");

        // 3: consumer stalled; issue must stop after FIFO_DEPTH pixels, then nothing is lost
        bus.out_ready = 1'b0;
        base = n_out;
        send(27'h3ab, 5'd2, 5'd13, 5'd5, 5'd5);
        prev = {bus.zi_y, bus.zi_x};
        cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cur = {bus.zi_y, bus.zi_x};
            if (cur != prev) cnt++;
            prev = cur;
        end
        check("t3_issued_while_stalled", cnt, FIFO_DEPTH);
        check("t3_out_valid", bus.out_valid, 1);
        check("t3_busy", bus.busy, 1);
        bus.out_ready = 1'b1;
        wait_idle("t3_idle");
        check("t3_count", n_out - base, 12);

        // 2: full tile at full throughput
        base = n_out;
        send(27'h5a5a5a5, 5'd0, 5'd31, 5'd0, 5'd31);
        wait_idle("t2_idle");
        check("t2_count", n_out - base, 1024);
        if (n_out - base == 1024) check("t2_span", cyc_log[base + 1023] - cyc_log[base], 1023);

        // 4: back-to-back records with different c
        send(27'h1000, 5'd0, 5'd2, 5'd0, 5'd1);
        check("t4_busy_after_a", bus.tri_ready, 0);
        send(27'h2000, 5'd3, 5'd4, 5'd7, 5'd7);
        wait_idle("t4_idle");

        // 5: empty box (x_min > x_max)
        base = n_out;
        send(27'h777, 5'd5, 5'd3, 5'd0, 5'd0);
        check("t5_tri_ready", bus.tri_ready, 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid || bus.busy) cnt++;
            tick();
        end
        check("t5_no_activity", cnt, 0);

        // 6: reset with three tokens in flight
        send(27'h4321, 5'd0, 5'd31, 5'd0, 5'd31);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_tri_ready", bus.tri_ready, 1);
        check("t6_busy", bus.busy, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) cnt++;
            tick();
        end
        check("t6_no_stale", cnt, 0);
        check("t6_tri_ready_after", bus.tri_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
